record_note: RTL

Write-side sequencer for the note memory. While the player records, it captures each played note into consecutive memory addresses and drives the write address, data and enable. On stop, it publishes the end-of-track limits, `limit` for the base track and `limit_mix` for the overdub track, which the playback read sequencer compares its read address against. It sits between the key/note decoder and the note RAM write port.

---
 rtl/record_note.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/record_note.sv
// record_note: write-side sequencer for the note memory.
// Captures strobed notes into consecutive RAM addresses while recording and
// publishes the end-of-track limits for the base and overdub tracks on stop.
// Optional feature: define REST_INSERT_EN to insert REST_CODE after
// REST_TICKS idle clocks while recording.
module record_note #(
  parameter int unsigned       NOTE_W     = 5,
  parameter logic [NOTE_W-1:0] REST_CODE  = '0,
  parameter logic [15:0]       REST_TICKS = 16'd50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record,
  input  logic              mix_audio,
  input  logic              note_strobe,
  input  logic [NOTE_W-1:0] note_in,
  output logic [6:0]        writeDirection,
  output logic [NOTE_W-1:0] writeData,
  output logic              writeEnable,
  output logic [5:0]        limit,
  output logic [6:0]        limit_mix,
  output logic              recording,
  output logic              full,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REC, COMMIT} state_t;

  state_t            state_q, state_d;
  logic              record_q, strobe_q;
  logic              mix_q, mix_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [7:0]        count_q, count_d;
  logic [6:0]        waddr_q, waddr_d;
  logic [NOTE_W-1:0] wdata_q, wdata_d;
  logic [5:0]        limit_q, limit_d;
  logic [6:0]        limit_mix_q, limit_mix_d;
  logic [6:0]        ptr_m1;
  logic              rec_edge, note_edge, rest_fire, ptr_over;

  assign rec_edge  = record & ~record_q;
  assign note_edge = note_strobe & ~strobe_q;
  // 7-bit result: an overdub that filled address 127 has ptr_q = 128.
  assign ptr_m1    = ptr_q[6:0] - 7'd1;
  assign ptr_over  = mix_q ? ptr_q[7] : (ptr_q[7:6] != 2'b00);

`ifdef REST_INSERT_EN
  logic [15:0] idle_q, idle_d;

  assign rest_fire = (state_q == REC) && !note_edge && !full_q &&
                     (idle_q == REST_TICKS - 16'd1);

  // Idle counter: counts REC cycles without a strobe edge, restarts on any write trigger.
  always_comb begin
    idle_d = idle_q + 16'd1;
    if (state_q != REC || note_edge || idle_q == REST_TICKS - 16'd1) begin
      idle_d = '0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign rest_fire = 1'b0;
`endif

  // Next-state and datapath decode for the IDLE/REC/COMMIT sequencer.
  always_comb begin
    state_d     = state_q;
    mix_d       = mix_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    limit_d     = limit_q;
    limit_mix_d = limit_mix_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    full_d      = ptr_over;
    unique case (state_q)
      IDLE: begin
        if (rec_edge) begin
          state_d = REC;
          mix_d   = mix_audio;
          ptr_d   = mix_audio ? ({2'b00, limit_q} + 8'd1) : '0;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      REC: begin
        if ((note_edge || rest_fire) && !full_q) begin
          we_d    = 1'b1;
          waddr_d = ptr_q[6:0];
          wdata_d = note_edge ? note_in : REST_CODE;
          ptr_d   = ptr_q + 8'd1;
          count_d = count_q + 8'd1;
        end
        if (!record) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (count_q != '0) begin
          if (!mix_q) begin
            limit_d     = ptr_m1[5:0];
            limit_mix_d = {1'b0, ptr_m1[5:0]};
          end else begin
            limit_mix_d = ptr_m1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      // Held high through reset so a record button still pressed does not
      // look like a fresh press once reset releases.
      record_q    <= 1'b1;
      strobe_q    <= 1'b0;
      mix_q       <= 1'b0;
      full_q      <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      limit_q     <= '0;
      limit_mix_q <= '0;
    end else begin
      state_q     <= state_d;
      record_q    <= record;
      strobe_q    <= note_strobe;
      mix_q       <= mix_d;
      full_q      <= full_d;
      we_q        <= we_d;
      done_q      <= done_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      limit_q     <= limit_d;
      limit_mix_q <= limit_mix_d;
    end
  end

  assign writeDirection = waddr_q;
  assign writeData      = wdata_q;
  assign writeEnable    = we_q;
  assign limit          = limit_q;
  assign limit_mix      = limit_mix_q;
  assign recording      = (state_q == REC);
  assign full           = full_q;
  assign done           = done_q;

endmodule
